// File: rtl/mem_hexdump_pkg.sv
// Shared definitions for the memory hex-dump transmitter: state encoding,
// ASCII constants and the nibble-to-ASCII helper.
// Optional feature macro: MEM_HEXDUMP_ADDR_EN (adds the '@addr' header state).
package mem_hexdump_pkg;

  // State encoding kept as plain constants so the state register can be
  // probed and compared like any other vector in legacy tooling.
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RD   = 3'd1;
  localparam state_t S_WAIT = 3'd2;
  localparam state_t S_DIG  = 3'd3;
  localparam state_t S_EOL  = 3'd4;
  localparam state_t S_DONE = 3'd5;
`ifdef MEM_HEXDUMP_ADDR_EN
  localparam state_t S_HDR  = 3'd6;
`endif

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A_OFS = 8'h37;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_AT    = 8'h40;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nib2asc(input logic [3:0] nib);
    if (nib < 4'd10) return ASC_0 + {4'h0, nib};
    return ASC_A_OFS + {4'h0, nib};
  endfunction

endpackage

// File: rtl/mem_hexdump_agen.sv
// Address generator for the hex dump: latches the inclusive range and its
// direction when a dump starts, then steps one address per pulse.
module mem_hexdump_agen
  import mem_hexdump_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              step,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  logic [ADDR_W-1:0] end_r;
  logic              desc;

  // Range latch and stepping; descending when the range is given high-to-low.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its peers regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      end_r    <= '0;
      desc     <= 1'b0;
    end else if (load) begin
      cur_addr <= start_addr;
      end_r    <= end_addr;
      desc     <= (start_addr > end_addr);
    end else if (step) begin
      cur_addr <= desc ? (cur_addr - ADDR_W'(1)) : (cur_addr + ADDR_W'(1));
    end
  end

  // The range is inclusive, so the walk stops on reaching end_r and the
  // address can never wrap around the RAM.
  assign last = (cur_addr == end_r);

endmodule

// File: rtl/mem_hexdump_tx.sv
// Memory hex-dump transmitter: reads an inclusive address range from a
// synchronous-read RAM and streams each word as uppercase ASCII hex, one
// word per line, over a valid/ready byte interface.
// Optional feature macro: MEM_HEXDUMP_ADDR_EN -- when defined, a line
// "@<start_addr in hex>\n" precedes the data.
module mem_hexdump_tx
  import mem_hexdump_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int NDIG = (DATA_W + 3) / 4;
  localparam int SH_W = NDIG * 4;
  localparam int DCW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [SH_W-1:0]   word_sh;
  logic [DCW-1:0]    dig_cnt;
  logic              dig_last;
  logic              agen_load;
  logic              agen_step;
  logic              agen_last;
  logic [ADDR_W-1:0] cur_addr;

  assign agen_load = (state == S_IDLE) && start;
  assign agen_step = (state == S_EOL) && tx_ready && !agen_last;
  assign dig_last  = (dig_cnt == DCW'(NDIG - 1));

  mem_hexdump_agen #(
    .ADDR_W (ADDR_W)
  ) u_agen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (agen_load),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .step       (agen_step),
    .cur_addr   (cur_addr),
    .last       (agen_last)
  );

`ifdef MEM_HEXDUMP_ADDR_EN
  localparam int ADIG  = (ADDR_W + 3) / 4;
  localparam int HSH_W = ADIG * 4;
  localparam int HCW   = $clog2(ADIG + 2);

  // Header byte index: 0 is '@', 1..ADIG are address digits, ADIG+1 is LF.
  logic [HSH_W-1:0] hdr_sh;
  logic [HCW-1:0]   hdr_idx;
  logic             hdr_last;

  assign hdr_last = (hdr_idx == HCW'(ADIG + 1));

  // Header sequencer: snapshot start_addr on accept, shift a digit out per
  // accepted digit byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_sh  <= '0;
      hdr_idx <= '0;
    end else if (agen_load) begin
      hdr_sh  <= HSH_W'(start_addr);
      hdr_idx <= '0;
    end else if ((state == S_HDR) && tx_ready) begin
      hdr_idx <= hdr_idx + HCW'(1);
      if (hdr_idx != '0) hdr_sh <= hdr_sh << 4;
    end
  end
`endif

  // Next-state logic; every transition out of a byte-emitting state waits
  // for the sink to accept the current byte.
  // NOTE: state_nxt is defaulted first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
`ifdef MEM_HEXDUMP_ADDR_EN
        if (start) state_nxt = S_HDR;
`else
        if (start) state_nxt = S_RD;
`endif
      end
`ifdef MEM_HEXDUMP_ADDR_EN
      S_HDR:  if (tx_ready && hdr_last) state_nxt = S_RD;
`endif
      S_RD:   state_nxt = S_WAIT;
      S_WAIT: state_nxt = S_DIG;
      S_DIG:  if (tx_ready && dig_last) state_nxt = S_EOL;
      S_EOL:  if (tx_ready) state_nxt = agen_last ? S_DONE : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus the word shift register feeding the digit stream.
  // The shift register only moves on acceptance, which keeps tx_data stable
  // for as long as the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      word_sh <= '0;
      dig_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT) begin
        word_sh <= SH_W'(mem_rdata);
        dig_cnt <= '0;
      end else if ((state == S_DIG) && tx_ready) begin
        word_sh <= word_sh << 4;
        dig_cnt <= dig_cnt + DCW'(1);
      end
    end
  end

  // Byte stream is decoded straight from the state so an asynchronous reset
  // drops tx_valid and clears tx_data without waiting for a clock edge.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
`ifdef MEM_HEXDUMP_ADDR_EN
      S_HDR: begin
        tx_valid = 1'b1;
        if (hdr_idx == '0)  tx_data = ASC_AT;
        else if (hdr_last)  tx_data = ASC_LF;
        else                tx_data = nib2asc(hdr_sh[HSH_W-1 -: 4]);
      end
`endif
      S_DIG: begin
        tx_valid = 1'b1;
        tx_data  = nib2asc(word_sh[SH_W-1 -: 4]);
      end
      S_EOL: begin
        tx_valid = 1'b1;
        tx_data  = ASC_LF;
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  // Status and RAM port; mem_addr simply follows the walker, which holds its
  // last value while idle.
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign mem_rd   = (state == S_RD);
  assign mem_addr = cur_addr;

endmodule
